// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the async FIFO write port between NREQ
// valid/ready requesters. All requesters are in the write clock domain. The
// winner of an arbitration keeps the port for a burst of up to MAXBURST words.
// The port is released early if the owner stops presenting data.
//
// Parameters
//   NREQ      number of requesters (>= 2)
//   DSIZE     data word width; must match the FIFO word width
//   MAXBURST  maximum words per grant (>= 1)
//
// Ports
//   wclk       in   write-domain clock; all state changes on its rising edge
//   wrst       in   synchronous active-high reset
//   req_valid  in   [NREQ]        per-requester word valid
//   req_data   in   [NREQ*DSIZE]  requester i drives bits [i*DSIZE +: DSIZE]
//   req_ready  out  [NREQ]        per-requester accept (valid & ready = transfer)
//   wfull      in   FIFO full flag
//   winc       out  FIFO write enable, one pulse per accepted word
//   wdata      out  [DSIZE]       FIFO write data
//   grant      out  [NREQ]        registered one-hot owner, all-zero when idle
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic [NREQ-1:0]         grant
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXBURST + 1);
  // Count value at which the next transfer completes the burst.
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAXBURST - 1);
  localparam logic [NREQ-1:0] ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_reg;
  logic [NREQ-1:0]   grant_reg;
  logic [IW-1:0]     owner_reg;
  logic [IW-1:0]     last_reg;
  logic [CW-1:0]     count_reg;

  logic [IW-1:0]     arb_idx_next;
  logic [NREQ-1:0]   arb_grant_next;
  logic              owner_valid;
  logic              active;
  logic              xfer;

  // Unpack the flat data bus into one word per requester.
  logic [DSIZE-1:0]  req_word [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*DSIZE +: DSIZE];
    end
  endgenerate

  // The port is only usable while owned and out of reset; reset gates the
  // handshake combinationally so no word can slip through in the reset cycle.
  assign active      = (state_reg == ST_GRANT) && !wrst;
  assign owner_valid = req_valid[owner_reg];
  assign xfer        = active && owner_valid && !wfull;

  assign winc  = xfer;
  assign wdata = req_word[owner_reg];
  assign grant = grant_reg;

  // Only the owner sees ready. Ready follows ~wfull even if the owner is not
  // presenting a word; without valid there is no transfer either way.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = active && !wfull && grant_reg[gi];
    end
  endgenerate

  // Cyclic search starting one past the last-served requester. The loop runs
  // from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    arb_idx_next = last_reg;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(last_reg) + k) % NREQ]) begin
        arb_idx_next = IW'((int'(last_reg) + k) % NREQ);
      end
    end
  end

  assign arb_grant_next = ONE_HOT_0 << arb_idx_next;

  // Arbitration FSM. IDLE always costs one cycle (no transfer there), which
  // keeps the grant and the data mux registered.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      owner_reg <= '0;
      count_reg <= '0;
      // Point at the last requester so requester 0 wins first after reset.
      last_reg  <= IW'(NREQ - 1);
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req_valid) begin
            state_reg <= ST_GRANT;
            grant_reg <= arb_grant_next;
            owner_reg <= arb_idx_next;
            count_reg <= '0;
          end
        end

        ST_GRANT: begin
          if (!owner_valid) begin
            // Owner went quiet: forfeit the port, it becomes lowest priority.
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            last_reg  <= owner_reg;
            count_reg <= '0;
          end else if (!wfull) begin
            if (count_reg == LAST_BEAT) begin
              // Final word of the burst is transferring now.
              state_reg <= ST_IDLE;
              grant_reg <= '0;
              last_reg  <= owner_reg;
              count_reg <= '0;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
          // wfull with valid held: stall, grant and count unchanged.
        end

        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= '0;
          count_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed and random stimulus for fifo_wr_arbiter. Each requester is modelled
// as a word queue; loading a word also records it in that requester's expected
// queue. A separate negedge monitor checks every FIFO write against the
// expected queue of the granted requester, plus per-cycle port invariants.
// Directed tests additionally compare winc/grant/req_ready cycle by cycle.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBURST = 4;

  logic                  wclk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       grant;

  fifo_wr_arbiter #(
    .NREQ     (NREQ),
    .DSIZE    (DSIZE),
    .MAXBURST (MAXBURST)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant)
  );

  always #5 wclk = ~wclk;

  // Hand-computed per-cycle traces for the directed tests.
  localparam logic [8:0]  T1_W = 9'b011011110;
  localparam logic [3:0]  T1_G [9]  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1};
  localparam logic [10:0] T3_W = 11'b01100000110;
  localparam logic [3:0]  T3_G [11] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
  localparam logic [6:0]  T4_W = 7'b0010010;
  localparam logic [3:0]  T4_G [7]  = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0};
  localparam logic [12:0] T5_W = 13'b0111100100110;
  localparam logic [3:0]  T5_G [13] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0,
                                        4'h8, 4'h8, 4'h8, 4'h8, 4'h0};

  logic [DSIZE-1:0] src_q [NREQ][$];   // words still to be offered
  logic [DSIZE-1:0] exp_q [NREQ][$];   // every word ever offered, in order
  int               rd_idx [NREQ] = '{default: 0};

  int n_checks = 0;
  int n_fails  = 0;

  logic [NREQ-1:0] en, en_nx;
  logic            wfull_nx, wrst_nx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int i, input logic [DSIZE-1:0] d);
    src_q[i].push_back(d);
    exp_q[i].push_back(d);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        req_valid[i]               = 1'b1;
        req_data[i*DSIZE +: DSIZE] = src_q[i][0];
      end else begin
        req_valid[i]               = 1'b0;
        req_data[i*DSIZE +: DSIZE] = '0;
      end
    end
  endtask

  // Advance one cycle: note this cycle's transfers, apply them after the edge,
  // update the controls, and return at the next negedge with outputs settled.
  task automatic tick();
    logic [NREQ-1:0] xfer;
    #1;
    xfer = req_valid & req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer[i]) src_q[i].delete(0);
    end
    wfull = wfull_nx;
    wrst  = wrst_nx;
    en    = en_nx;
    drive();
    @(negedge wclk);
  endtask

  // Compare this cycle's port state with the expected winc/grant. Ready is
  // expected on the owner only, and only outside reset and full.
  task automatic cyc(input string name, input logic ew, input logic [NREQ-1:0] eg);
    chk({name, "_winc"}, winc, ew);
    chk({name, "_grant"}, grant, eg);
    chk({name, "_ready"}, req_ready, (wrst || wfull) ? '0 : eg);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Scoreboard monitor.
  always @(negedge wclk) begin
    int o;
    chk("grant_onehot0", $onehot0(grant), 1);
    chk("winc_vs_handshake", winc, |(req_valid & req_ready));
    if (winc) begin
      chk("winc_while_full", wfull, 0);
      chk("winc_in_reset", wrst, 0);
      chk("winc_with_grant", |grant, 1);
      o = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) o = i;
      end
      if (rd_idx[o] < exp_q[o].size()) begin
        $display("WR req %0d data %02h", o, wdata);
        chk($sformatf("wdata_req%0d_word%0d", o, rd_idx[o]), wdata, exp_q[o][rd_idx[o]]);
        rd_idx[o] = rd_idx[o] + 1;
      end else begin
        n_checks++;
        n_fails++;
        $display("FAIL extra_word: req %0d wrote %02h beyond %0d expected words", o, wdata, exp_q[o].size());
      end
    end
  end

  initial begin
    wrst      = 1'b1;
    wfull     = 1'b0;
    en        = '0;
    wrst_nx   = 1'b1;
    wfull_nx  = 1'b0;
    en_nx     = '0;
    req_valid = '0;
    req_data  = '0;
    drive();
    @(negedge wclk);
    tick();
    tick();
    cyc("reset", 1'b0, 4'h0);

    // 1: single requester, six words -> burst of 4, bubble, burst of 2.
    for (int d = 8'h10; d <= 8'h15; d++) load(0, 8'(d));
    wrst_nx = 1'b0;
    en_nx   = 4'b0001;
    tick();
    for (int k = 0; k < 9; k++) begin
      cyc($sformatf("t1_c%0d", k), T1_W[k], T1_G[k]);
      tick();
    end
    cyc("t1_end", 1'b0, 4'h0);

    // 2: all requesters busy after a reset -> grants 0,1,2,3,0.
    for (int d = 0; d < 8; d++) load(0, 8'(8'h40 + d));
    for (int i = 1; i < NREQ; i++) begin
      for (int d = 0; d < 4; d++) load(i, 8'(8'h40 + 16 * i + d));
    end
    wrst_nx = 1'b1;
    en_nx   = 4'b1111;
    tick();
    cyc("t2_reset", 1'b0, 4'h0);
    wrst_nx = 1'b0;
    tick();
    for (int b = 0; b < 5; b++) begin
      cyc($sformatf("t2_gap%0d", b), 1'b0, 4'h0);
      tick();
      for (int w = 0; w < MAXBURST; w++) begin
        cyc($sformatf("t2_b%0d_w%0d", b, w), 1'b1, 4'(1 << (b % NREQ)));
        tick();
      end
    end
    cyc("t2_end", 1'b0, 4'h0);

    // 3: owner 2 stalled by wfull for 5 cycles with count at 2.
    for (int d = 0; d < 4; d++) load(2, 8'(8'h80 + d));
    en_nx = 4'b0100;
    tick();
    for (int k = 0; k < 11; k++) begin
      cyc($sformatf("t3_c%0d", k), T3_W[k], T3_G[k]);
      wfull_nx = (k + 1 >= 3) && (k + 1 <= 7);
      tick();
    end

    // 4: owner 1 stops after one word while requester 3 waits.
    load(1, 8'h91);
    en_nx = 4'b0010;
    tick();
    load(3, 8'hA1);
    for (int k = 0; k < 7; k++) begin
      cyc($sformatf("t4_c%0d", k), T4_W[k], T4_G[k]);
      en_nx = 4'b1010;
      tick();
    end

    // 5: reset in the middle of requester 3's burst.
    for (int d = 0; d < 6; d++) load(3, 8'(8'hB0 + d));
    en_nx = 4'b1000;
    tick();
    load(0, 8'hC0);
    for (int k = 0; k < 13; k++) begin
      cyc($sformatf("t5_c%0d", k), T5_W[k], T5_G[k]);
      wrst_nx = (k + 1 == 3);
      en_nx   = (k + 1 >= 3) ? 4'b1001 : 4'b1000;
      tick();
    end

    // 6: random valid and wfull; the monitor checks every word.
    for (int i = 0; i < NREQ; i++) begin
      for (int d = 0; d < 80; d++) load(i, 8'($urandom_range(0, 255)));
    end
    for (int c = 0; c < 4000 && !all_empty(); c++) begin
      en_nx    = 4'($urandom_range(0, 15));
      wfull_nx = ($urandom_range(0, 9) < 3);
      tick();
    end
    en_nx    = 4'b1111;
    wfull_nx = 1'b0;
    for (int c = 0; c < 1000 && !all_empty(); c++) tick();
    en_nx = '0;
    tick();
    tick();
    cyc("t6_idle", 1'b0, 4'h0);
    for (int i = 0; i < NREQ; i++) begin
      chk($sformatf("words_written_req%0d", i), rd_idx[i], exp_q[i].size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
